// File: rtl/chess_pkg.sv
// Shared board/square widths, the empty-square code and the move sequencer states.
// Imported by every block that touches the 64x5 board RAM.
package chess_pkg;

    localparam int SQ_W    = 6;
    localparam int PIECE_W = 5;

    localparam logic [PIECE_W-1:0] EMPTY = 5'b00000;

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
        RD_DST,
        CHK,
        WR_DST,
        WR_SRC,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/chess_move_executor.sv
// Executes one (src, dst) move against the single-port board RAM: read both squares,
// write the piece to dst, clear src, report the captured code and count successful moves.
module chess_move_executor
    import chess_pkg::*;
#(
    parameter int MOVE_CNT_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic [SQ_W-1:0]       src,
    input  logic [SQ_W-1:0]       dst,
    output logic                  ram_en,
    output logic                  ram_rw,
    output logic [SQ_W-1:0]       ram_addr,
    output logic [PIECE_W-1:0]    ram_wdata,
    input  logic [PIECE_W-1:0]    ram_rdata,
    output logic                  done,
    output logic                  error,
    output logic [PIECE_W-1:0]    captured,
    output logic [MOVE_CNT_W-1:0] move_count
);

    state_t                  state;
    state_t                  state_nxt;
    logic [SQ_W-1:0]         src_r;
    logic [SQ_W-1:0]         dst_r;
    logic [PIECE_W-1:0]      piece_r;
    logic [PIECE_W-1:0]      cap_r;
    logic [PIECE_W-1:0]      captured_r;
    logic [MOVE_CNT_W-1:0]   count_r;
    logic                    ram_en_st;
    logic                    accept;

    assign accept = move_valid && move_ready;

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            src_r      <= '0;
            dst_r      <= '0;
            piece_r    <= EMPTY;
            cap_r      <= EMPTY;
            captured_r <= EMPTY;
            count_r    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                src_r <= src;
                dst_r <= dst;
            end
            // RAM data is registered, so each latch picks up the read issued one state earlier.
            if (state == RD_DST) piece_r <= ram_rdata;
            if (state == CHK)    cap_r   <= ram_rdata;
            // Publish the result on entry to DONE so it is visible while done is high.
            if (state == WR_SRC) begin
                captured_r <= cap_r;
                count_r    <= count_r + MOVE_CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default before the case statement,
    // which is what keeps synthesis from inferring latches on unlisted paths.
    always_comb begin
        state_nxt  = state;
        move_ready = 1'b0;
        ram_en_st  = 1'b0;
        ram_rw     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = EMPTY;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            IDLE: begin
                move_ready = 1'b1;
                if (move_valid) state_nxt = (src == dst) ? ERR : RD_SRC;
            end
            RD_SRC: begin
                ram_en_st = 1'b1;
                ram_addr  = src_r;
                state_nxt = RD_DST;
            end
            RD_DST: begin
                ram_en_st = 1'b1;
                ram_addr  = dst_r;
                state_nxt = CHK;
            end
            CHK: begin
                state_nxt = (piece_r == EMPTY) ? ERR : WR_DST;
            end
            WR_DST: begin
                ram_en_st = 1'b1;
                ram_rw    = 1'b1;
                ram_addr  = dst_r;
                ram_wdata = piece_r;
                state_nxt = WR_SRC;
            end
            WR_SRC: begin
                ram_en_st = 1'b1;
                ram_rw    = 1'b1;
                ram_addr  = src_r;
                ram_wdata = EMPTY;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                done      = 1'b1;
                error     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset suppresses the RAM strobe in the same cycle, so a pending write never lands.
    assign ram_en     = ram_en_st && reset;
    assign captured   = captured_r;
    assign move_count = count_r;

endmodule

// File: tb/tb_chess_move_executor.sv
// Randomised scoreboard bench for chess_move_executor with a behavioural board model
// and a small registered RAM standing in for the 64x5 board memory.
module tb_chess_move_executor;

    localparam int CNT_W = 2;
    localparam int CNT_M = 1 << CNT_W;

    typedef struct {
        logic       err;
        logic [4:0] cap;
        int         cnt;
        int         acc;
        int         lat;
        int         nen;
        int         nwr;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             move_valid;
    logic             move_ready;
    logic [5:0]       src;
    logic [5:0]       dst;
    logic             ram_en;
    logic             ram_rw;
    logic [5:0]       ram_addr;
    logic [4:0]       ram_wdata;
    logic [4:0]       ram_rdata;
    logic             done;
    logic             error;
    logic [4:0]       captured;
    logic [CNT_W-1:0] move_count;

    logic [4:0] mem [64];
    logic [4:0] board [64];
    logic       pre_we;
    logic [5:0] pre_addr;
    logic [4:0] pre_data;

    exp_t exp_q[$];
    int   model_cnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_en = 0;
    int   n_wr = 0;
    bit   b2b = 0;
    int   prev_c0 = 0;
    int   prev_lat = 0;

    chess_move_executor #(.MOVE_CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .src        (src),
        .dst        (dst),
        .ram_en     (ram_en),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .done       (done),
        .error      (error),
        .captured   (captured),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM: registered read, write on enable; the bench preload port has priority.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_en) begin
            if (ram_rw) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: a move is rules applied to an array, with fixed cycle costs per outcome.
    function automatic exp_t model_move(input int s, input int d, input int c0);
        exp_t e;
        e.acc = c0;
        e.cap = 5'd0;
        if (s == d) begin
            e.err = 1'b1; e.lat = 1; e.nen = 0; e.nwr = 0;
        end else if (board[s] == 5'd0) begin
            e.err = 1'b1; e.lat = 4; e.nen = 2; e.nwr = 0;
        end else begin
            e.err = 1'b0; e.lat = 6; e.nen = 4; e.nwr = 2;
            e.cap = board[d];
            board[d] = board[s];
            board[s] = 5'd0;
            model_cnt = (model_cnt + 1) % CNT_M;
        end
        e.cnt = model_cnt;
        return e;
    endfunction

    // Monitor: counts RAM traffic per move and scores each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            n_en = 0;
            n_wr = 0;
        end else begin
            if (ram_en) begin
                n_en++;
                if (ram_rw) n_wr++;
            end
            if (!ram_rw) check("wdata_zero_when_not_writing", int'(ram_wdata), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("error", int'(error), int'(e.err));
                    check("done_latency", cyc - e.acc, e.lat);
                    check("ram_accesses", n_en, e.nen);
                    check("ram_writes", n_wr, e.nwr);
                    check("move_count", int'(move_count), e.cnt);
                    if (!e.err) check("captured", int'(captured), int'(e.cap));
                end
                n_en = 0;
                n_wr = 0;
            end
        end
    end

    task automatic poke(input int a, input logic [4:0] v);
        pre_we   = 1'b1;
        pre_addr = a[5:0];
        pre_data = v;
        board[a] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!move_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = move_ready;
    endtask

    // Called on a negedge; returns on the negedge after acceptance with move_valid still high.
    task automatic do_move(input int s, input int d);
        bit   ok;
        int   c0;
        exp_t e;
        move_valid = 1'b1;
        src = s[5:0];
        dst = d[5:0];
        wait_ready(ok);
        if (!ok) begin
            check("accept_timeout", 0, 1);
            return;
        end
        c0 = cyc;
        if (b2b) check("accept_gap", c0 - prev_c0, prev_lat + 1);
        e = model_move(s, d, c0);
        exp_q.push_back(e);
        prev_c0  = c0;
        prev_lat = e.lat;
        b2b      = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        move_valid = 1'b0;
        b2b = 1'b0;
        while ((exp_q.size() != 0 || !move_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Reset dropped during WR_SRC: dst already holds the piece, src keeps it too.
    task automatic abort_move(input int s, input int d);
        bit ok;
        int c0;
        move_valid = 1'b1;
        src = s[5:0];
        dst = d[5:0];
        wait_ready(ok);
        if (!ok) begin
            check("abort_accept_timeout", 0, 1);
            return;
        end
        c0 = cyc;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        while (cyc < c0 + 5) @(negedge clk);
        reset = 1'b0;
        board[d] = board[s];
        model_cnt = 0;
        @(negedge clk);
        check("abort_ram_en", int'(ram_en), 0);
        check("abort_done", int'(done), 0);
        check("abort_ready", int'(move_ready), 1);
        check("abort_move_count", int'(move_count), model_cnt);
        reset = 1'b1;
        b2b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int d;
        reset      = 1'b0;
        move_valid = 1'b0;
        src        = '0;
        dst        = '0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;
        repeat (3) @(negedge clk);

        check("rst_move_ready", int'(move_ready), 1);
        check("rst_ram_en", int'(ram_en), 0);
        check("rst_ram_rw", int'(ram_rw), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_wdata", int'(ram_wdata), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_captured", int'(captured), 0);
        check("rst_move_count", int'(move_count), 0);

        for (int i = 0; i < 64; i++)
            poke(i, ($urandom_range(0, 1) != 0) ? 5'($urandom_range(1, 31)) : 5'd0);
        poke(8, 5'b00001);
        poke(16, 5'b00000);
        poke(1, 5'b10111);
        poke(9, 5'b00010);
        poke(20, 5'b00000);
        poke(40, 5'b01010);
        reset = 1'b1;
        @(negedge clk);

        abort_move(40, 41);

        do_move(8, 16);
        do_move(1, 9);
        do_move(20, 28);
        do_move(12, 12);
        do_move(16, 33);
        do_move(9, 44);
        do_move(33, 50);
        wait_idle();

        for (int n = 0; n < 160; n++) begin
            if (n % 40 == 39) begin
                wait_idle();
                for (int k = 0; k < 10; k++)
                    poke($urandom_range(0, 63), 5'($urandom_range(1, 31)));
            end
            s = $urandom_range(0, 63);
            d = ($urandom_range(0, 7) == 0) ? s : $urandom_range(0, 63);
            do_move(s, d);
        end
        wait_idle();

        for (int i = 0; i < 64; i++)
            check($sformatf("board_sq%0d", i), int'(mem[i]), int'(board[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
